// File: rtl/axi_store_writer_if.sv
// -----------------------------------------------------------------------------
// axi_store_writer_if
// Bundles the store request channel and the AXI4 write channels (AW, W, B)
// used by axi_store_writer.
//
// Modports:
//   master : the store writer. It receives store requests and drives the AXI
//            write address/data channels and bready.
//   slave  : the environment. It issues store requests and plays the AXI
//            write slave.
//
// Signal groups:
//   req_*      store request from the execute stage, plus done/err status
//   m_axi_aw*  write address channel
//   m_axi_w*   write data channel
//   m_axi_b*   write response channel
// -----------------------------------------------------------------------------
interface axi_store_writer_if #(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    // Store request side
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_data;
    logic [1:0]            req_size;
    logic                  done;
    logic                  err;

    // AXI write address channel
    logic [ID_WIDTH-1:0]   m_axi_awid;
    logic [ADDR_WIDTH-1:0] m_axi_awaddr;
    logic [7:0]            m_axi_awlen;
    logic [2:0]            m_axi_awsize;
    logic [1:0]            m_axi_awburst;
    logic                  m_axi_awvalid;
    logic                  m_axi_awready;

    // AXI write data channel
    logic [DATA_WIDTH-1:0] m_axi_wdata;
    logic [STRB_WIDTH-1:0] m_axi_wstrb;
    logic                  m_axi_wlast;
    logic                  m_axi_wvalid;
    logic                  m_axi_wready;

    // AXI write response channel
    logic [1:0]            m_axi_bresp;
    logic                  m_axi_bvalid;
    logic                  m_axi_bready;

    modport master (
        input  req_valid, req_addr, req_data, req_size,
        output req_ready, done, err,
        output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize,
               m_axi_awburst, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bresp, m_axi_bvalid,
        output m_axi_bready
    );

    modport slave (
        output req_valid, req_addr, req_data, req_size,
        input  req_ready, done, err,
        input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize,
               m_axi_awburst, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready
    );
endinterface

// File: rtl/axi_store_writer.sv
// -----------------------------------------------------------------------------
// axi_store_writer
// Turns a single store request (byte/half/word/dword) into one single-beat
// AXI4 write: AW and W are issued together, the B response is collected, and
// a one-cycle done pulse with err status is returned. Misaligned stores are
// rejected without any AXI traffic.
//
// Ports:
//   clk   rising-edge clock
//   reset asynchronous active-high reset
//   bus   axi_store_writer_if.master (request, status, AXI AW/W/B channels)
//
// Build option:
//   STORE_BRESP_CHECK_EN  when defined, a SLVERR/DECERR write response also
//                         raises err; otherwise bresp is ignored and err
//                         reports misalignment only.
// -----------------------------------------------------------------------------
module axi_store_writer #(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input logic                clk,
    input logic                reset,
    axi_store_writer_if.master bus
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SEND   = 2'b01,
        WAIT_B = 2'b10,
        RESP   = 2'b11
    } state_t;

    // Strobe pattern for an access of 2^size bytes starting at lane 0.
    function automatic logic [STRB_WIDTH-1:0] size_strobe(input logic [1:0] size);
        case (size)
            2'd0:    size_strobe = STRB_WIDTH'(8'h01);
            2'd1:    size_strobe = STRB_WIDTH'(8'h03);
            2'd2:    size_strobe = STRB_WIDTH'(8'h0F);
            2'd3:    size_strobe = STRB_WIDTH'(8'hFF);
            default: size_strobe = STRB_WIDTH'(8'h00);
        endcase
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input logic [1:0] size);
        case (size)
            2'd0:    align_mask = 3'b000;
            2'd1:    align_mask = 3'b001;
            2'd2:    align_mask = 3'b011;
            2'd3:    align_mask = 3'b111;
            default: align_mask = 3'b111;
        endcase
    endfunction

    state_t                state_r;
    state_t                state_next_s;
    logic                  req_ready_r;
    logic                  req_ready_next_s;
    logic                  aw_valid_r;
    logic                  aw_valid_next_s;
    logic                  w_valid_r;
    logic                  w_valid_next_s;
    logic                  bready_r;
    logic                  bready_next_s;
    logic                  done_r;
    logic                  done_next_s;
    logic                  err_r;
    logic                  err_next_s;

    logic [ADDR_WIDTH-1:0] addr_r;
    logic [1:0]            size_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [STRB_WIDTH-1:0] wstrb_r;

    logic                  capture_s;
    logic [2:0]            lane_off_s;
    logic                  misaligned_s;
    logic                  bresp_err_s;

    assign lane_off_s   = bus.req_addr[2:0];
    assign misaligned_s = |(lane_off_s & align_mask(bus.req_size));

`ifdef STORE_BRESP_CHECK_EN
    // bresp[1] set means SLVERR (2'b10) or DECERR (2'b11).
    assign bresp_err_s = bus.m_axi_bresp[1];
`else
    assign bresp_err_s = 1'b0;
`endif

    // Next-state and next-output logic; all outputs are registered from these.
    always_comb begin
        state_next_s     = state_r;
        req_ready_next_s = req_ready_r;
        aw_valid_next_s  = aw_valid_r;
        w_valid_next_s   = w_valid_r;
        bready_next_s    = bready_r;
        done_next_s      = 1'b0;
        err_next_s       = 1'b0;
        capture_s        = 1'b0;

        case (state_r)
            IDLE: begin
                if (bus.req_valid && req_ready_r) begin
                    capture_s        = 1'b1;
                    req_ready_next_s = 1'b0;
                    if (misaligned_s) begin
                        state_next_s = RESP;
                        done_next_s  = 1'b1;
                        err_next_s   = 1'b1;
                    end else begin
                        state_next_s    = SEND;
                        aw_valid_next_s = 1'b1;
                        w_valid_next_s  = 1'b1;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end

            SEND: begin
                if (aw_valid_r && bus.m_axi_awready) begin
                    aw_valid_next_s = 1'b0;
                end else begin
                    aw_valid_next_s = aw_valid_r;
                end
                if (w_valid_r && bus.m_axi_wready) begin
                    w_valid_next_s = 1'b0;
                end else begin
                    w_valid_next_s = w_valid_r;
                end
                // A channel is finished if it already handshook (valid low)
                // or handshakes this cycle; both may complete together.
                if ((!aw_valid_r || bus.m_axi_awready) &&
                    (!w_valid_r  || bus.m_axi_wready)) begin
                    state_next_s  = WAIT_B;
                    bready_next_s = 1'b1;
                end else begin
                    state_next_s = SEND;
                end
            end

            WAIT_B: begin
                if (bus.m_axi_bvalid) begin
                    state_next_s  = RESP;
                    bready_next_s = 1'b0;
                    done_next_s   = 1'b1;
                    err_next_s    = bresp_err_s;
                end else begin
                    state_next_s = WAIT_B;
                end
            end

            RESP: begin
                // A request presented now is not accepted: req_ready is low.
                state_next_s     = IDLE;
                req_ready_next_s = 1'b1;
            end

            default: begin
                state_next_s     = IDLE;
                req_ready_next_s = 1'b1;
                aw_valid_next_s  = 1'b0;
                w_valid_next_s   = 1'b0;
                bready_next_s    = 1'b0;
            end
        endcase
    end

    // State and handshake/status output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            req_ready_r <= 1'b1;
            aw_valid_r  <= 1'b0;
            w_valid_r   <= 1'b0;
            bready_r    <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            req_ready_r <= req_ready_next_s;
            aw_valid_r  <= aw_valid_next_s;
            w_valid_r   <= w_valid_next_s;
            bready_r    <= bready_next_s;
            done_r      <= done_next_s;
            err_r       <= err_next_s;
        end
    end

    // Request capture: lane shifting is done once at accept so the AXI
    // payload is held stable straight from registers until its handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_r  <= '0;
            size_r  <= 2'b00;
            wdata_r <= '0;
            wstrb_r <= '0;
        end else if (capture_s) begin
            addr_r  <= bus.req_addr;
            size_r  <= bus.req_size;
            wdata_r <= bus.req_data << {lane_off_s, 3'b000};
            wstrb_r <= size_strobe(bus.req_size) << lane_off_s;
        end else begin
            addr_r  <= addr_r;
            size_r  <= size_r;
            wdata_r <= wdata_r;
            wstrb_r <= wstrb_r;
        end
    end

    assign bus.req_ready     = req_ready_r;
    assign bus.done          = done_r;
    assign bus.err           = err_r;

    assign bus.m_axi_awid    = {ID_WIDTH{1'b0}};
    assign bus.m_axi_awaddr  = addr_r;
    assign bus.m_axi_awlen   = 8'h00;
    assign bus.m_axi_awsize  = {1'b0, size_r};
    assign bus.m_axi_awburst = 2'b01;
    assign bus.m_axi_awvalid = aw_valid_r;

    assign bus.m_axi_wdata   = wdata_r;
    assign bus.m_axi_wstrb   = wstrb_r;
    assign bus.m_axi_wlast   = 1'b1;
    assign bus.m_axi_wvalid  = w_valid_r;

    assign bus.m_axi_bready  = bready_r;
endmodule

// File: tb/tb_axi_store_writer.sv
// -----------------------------------------------------------------------------
// tb_axi_store_writer
// Self-checking bench for axi_store_writer: a table of directed stores, a
// reset-during-WAIT_B sequence and randomized stores checked against a
// byte-level reference model. Honors STORE_BRESP_CHECK_EN for err.
// -----------------------------------------------------------------------------
module tb_axi_store_writer;
    localparam int ID_WIDTH   = 13;
    localparam int ADDR_WIDTH = 64;
    localparam int DATA_WIDTH = 64;

`ifdef STORE_BRESP_CHECK_EN
    localparam bit BRESP_CHK = 1'b1;
`else
    localparam bit BRESP_CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    axi_store_writer_if #(
        .ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)
    ) bus ();

    axi_store_writer #(
        .ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic [1:0]  size;
        int          awd;
        int          wd;
        int          bd;
        logic [1:0]  bresp;
        logic [63:0] e_wdata;
        logic [7:0]  e_strb;
        bit          e_mis;
        bit          e_err;
        int          e_done;
    } vec_t;

    vec_t vecs[8];

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endfunction

    // Reference model: byte-lane view of the store.
    function automatic logic [7:0] m_strb(input logic [63:0] a, input logic [1:0] sz);
        int off;
        int nb;
        logic [7:0] s;
        off = int'(a % 64'd8);
        nb  = 1 << sz;
        s   = 8'h00;
        for (int i = 0; i < 8; i++)
            if (i >= off && i < off + nb) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] m_wdata(input logic [63:0] a, input logic [63:0] d);
        int off;
        logic [63:0] w;
        off = int'(a % 64'd8);
        w   = 64'h0;
        for (int i = 0; i < 8; i++)
            if (i >= off) w[8*i +: 8] = d[8*(i-off) +: 8];
        return w;
    endfunction

    function automatic bit m_mis(input logic [63:0] a, input logic [1:0] sz);
        return (a % (64'd1 << sz)) != 64'd0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One store with the bench acting as AXI slave. awd/wd: cycles of
    // awready/wready delay after SEND starts; bd: extra bvalid delay after
    // both handshakes. Cycle 0 is the accept cycle.
    task automatic do_store(input string nm, input logic [63:0] a, input logic [63:0] d,
                            input logic [1:0] sz, input int awd, input int wd, input int bd,
                            input logic [1:0] br, input logic [63:0] e_wdata,
                            input logic [7:0] e_strb, input bit e_mis, input bit e_err,
                            input int e_done);
        int aw_cnt, w_cnt, br_cnt, br_first, aw_c, w_c, b_c, done_c, hs_max, e_hs;
        logic err_o;
        aw_cnt = 0; w_cnt = 0; br_cnt = 0; br_first = -1;
        aw_c = 0; w_c = 0; b_c = 0; done_c = -1; err_o = 1'b0;

        bus.req_valid     = 1'b1;
        bus.req_addr      = a;
        bus.req_data      = d;
        bus.req_size      = sz;
        bus.m_axi_awready = 1'b0;
        bus.m_axi_wready  = 1'b0;
        bus.m_axi_bvalid  = 1'b0;
        bus.m_axi_bresp   = br;
        chk({nm, "_req_ready"}, bus.req_ready, 64'd1);

        for (int cyc = 1; cyc <= 60 && done_c < 0; cyc++) begin
            step();
            if (cyc == 1) begin
                // Scramble request inputs: the DUT must work from its capture.
                bus.req_valid = 1'b0;
                bus.req_addr  = ~a;
                bus.req_data  = ~d;
                bus.req_size  = ~sz;
            end
            bus.m_axi_awready = (cyc >= 1 + awd);
            bus.m_axi_wready  = (cyc >= 1 + wd);
            hs_max = (aw_c > w_c) ? aw_c : w_c;
            bus.m_axi_bvalid  = (aw_c > 0 && w_c > 0 && b_c == 0 && cyc >= hs_max + 1 + bd);

            if (bus.m_axi_awvalid) begin
                aw_cnt++;
                chk({nm, "_awaddr"}, bus.m_axi_awaddr, a);
                chk({nm, "_awsize"}, bus.m_axi_awsize, {62'd0, sz});
                if (bus.m_axi_awready && aw_c == 0) aw_c = cyc;
            end
            if (bus.m_axi_wvalid) begin
                w_cnt++;
                chk({nm, "_wdata"}, bus.m_axi_wdata, e_wdata);
                chk({nm, "_wstrb"}, bus.m_axi_wstrb, {56'd0, e_strb});
                if (bus.m_axi_wready && w_c == 0) w_c = cyc;
            end
            if (bus.m_axi_bready) begin
                br_cnt++;
                if (br_first < 0) br_first = cyc;
                if (bus.m_axi_bvalid && b_c == 0) b_c = cyc;
            end
            if (bus.done) begin
                done_c = cyc;
                err_o  = bus.err;
            end
        end

        e_hs = ((awd > wd) ? awd : wd) + 1;
        chk({nm, "_done_cycle"}, done_c, e_done);
        chk({nm, "_err"}, err_o, {63'd0, e_err});
        chk({nm, "_awvalid_cycles"}, aw_cnt, e_mis ? 0 : 1 + awd);
        chk({nm, "_wvalid_cycles"}, w_cnt, e_mis ? 0 : 1 + wd);
        chk({nm, "_bready_cycles"}, br_cnt, e_mis ? 0 : 1 + bd);
        chk({nm, "_bready_first"}, br_first, e_mis ? -1 : e_hs + 1);

        // Present a new aligned request during RESP; it must be ignored.
        bus.req_valid     = 1'b1;
        bus.req_addr      = a & ~64'h7;
        bus.req_size      = 2'd3;
        bus.m_axi_bvalid  = 1'b0;
        bus.m_axi_awready = 1'b0;
        bus.m_axi_wready  = 1'b0;
        step();
        bus.req_valid = 1'b0;
        chk({nm, "_post_done"}, bus.done, 64'd0);
        chk({nm, "_post_req_ready"}, bus.req_ready, 64'd1);
        chk({nm, "_post_awvalid"}, bus.m_axi_awvalid, 64'd0);
    endtask

    initial begin
        logic [63:0] ra, rd;
        logic [1:0]  rsz, rbr;
        int          rawd, rwd, rbd, rdone;
        bit          rmis;

        vecs[0] = '{64'h8000_0000, 64'h1122_3344_5566_7788, 2'd3, 0, 0, 0, 2'b00,
                    64'h1122_3344_5566_7788, 8'hFF, 1'b0, 1'b0, 3};
        vecs[1] = '{64'h8000_0005, 64'h0000_0000_0000_00AB, 2'd0, 0, 0, 0, 2'b00,
                    64'h0000_AB00_0000_0000, 8'h20, 1'b0, 1'b0, 3};
        vecs[2] = '{64'h8000_0004, 64'h0000_0000_DEAD_BEEF, 2'd2, 3, 0, 0, 2'b00,
                    64'hDEAD_BEEF_0000_0000, 8'hF0, 1'b0, 1'b0, 6};
        vecs[3] = '{64'h8000_0003, 64'h0000_0000_0000_1234, 2'd1, 0, 0, 0, 2'b00,
                    64'h0, 8'h00, 1'b1, 1'b1, 1};
        vecs[4] = '{64'h8000_0008, 64'hCAFE_F00D_1234_5678, 2'd3, 0, 0, 0, 2'b10,
                    64'hCAFE_F00D_1234_5678, 8'hFF, 1'b0, BRESP_CHK, 3};
        vecs[5] = '{64'h8000_0006, 64'h0000_0000_0000_BEEF, 2'd1, 0, 2, 1, 2'b00,
                    64'hBEEF_0000_0000_0000, 8'hC0, 1'b0, 1'b0, 6};
        vecs[6] = '{64'h8000_0002, 64'h0000_0000_0000_55AA, 2'd1, 1, 1, 0, 2'b11,
                    64'h0000_0000_55AA_0000, 8'h0C, 1'b0, BRESP_CHK, 4};
        vecs[7] = '{64'h8000_0006, 64'h0000_0000_0102_0304, 2'd2, 0, 0, 0, 2'b00,
                    64'h0, 8'h00, 1'b1, 1'b1, 1};

        bus.req_valid     = 1'b0;
        bus.req_addr      = 64'h0;
        bus.req_data      = 64'h0;
        bus.req_size      = 2'd0;
        bus.m_axi_awready = 1'b0;
        bus.m_axi_wready  = 1'b0;
        bus.m_axi_bvalid  = 1'b0;
        bus.m_axi_bresp   = 2'b00;
        reset = 1'b1;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_req_ready", bus.req_ready, 64'd1);
        chk("rst_done", bus.done, 64'd0);
        chk("rst_err", bus.err, 64'd0);
        chk("rst_awvalid", bus.m_axi_awvalid, 64'd0);
        chk("rst_wvalid", bus.m_axi_wvalid, 64'd0);
        chk("rst_bready", bus.m_axi_bready, 64'd0);
        chk("rst_awaddr", bus.m_axi_awaddr, 64'd0);
        chk("rst_wdata", bus.m_axi_wdata, 64'd0);
        chk("rst_wstrb", bus.m_axi_wstrb, 64'd0);
        chk("rst_awsize", bus.m_axi_awsize, 64'd0);
        chk("const_awid", bus.m_axi_awid, 64'd0);
        chk("const_awlen", bus.m_axi_awlen, 64'd0);
        chk("const_awburst", bus.m_axi_awburst, 64'd1);
        chk("const_wlast", bus.m_axi_wlast, 64'd1);
        reset = 1'b0;
        step();

        // Directed table
        for (int i = 0; i < 8; i++) begin
            do_store($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].size,
                     vecs[i].awd, vecs[i].wd, vecs[i].bd, vecs[i].bresp, vecs[i].e_wdata,
                     vecs[i].e_strb, vecs[i].e_mis, vecs[i].e_err, vecs[i].e_done);
        end

        // Reset while waiting for the write response
        bus.req_valid     = 1'b1;
        bus.req_addr      = 64'h8000_0010;
        bus.req_data      = 64'h0123_4567_89AB_CDEF;
        bus.req_size      = 2'd3;
        bus.m_axi_awready = 1'b1;
        bus.m_axi_wready  = 1'b1;
        bus.m_axi_bvalid  = 1'b0;
        step();
        bus.req_valid = 1'b0;
        step();
        chk("rstb_pre_bready", bus.m_axi_bready, 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("rstb_bready", bus.m_axi_bready, 64'd0);
        chk("rstb_req_ready", bus.req_ready, 64'd1);
        chk("rstb_awvalid", bus.m_axi_awvalid, 64'd0);
        chk("rstb_wvalid", bus.m_axi_wvalid, 64'd0);
        chk("rstb_done", bus.done, 64'd0);
        bus.m_axi_awready = 1'b0;
        bus.m_axi_wready  = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("rstb_idle_done%0d", c), bus.done, 64'd0);
            chk($sformatf("rstb_idle_awvalid%0d", c), bus.m_axi_awvalid, 64'd0);
            chk($sformatf("rstb_idle_req_ready%0d", c), bus.req_ready, 64'd1);
        end
        do_store("rstb_next", vecs[0].addr, vecs[0].data, vecs[0].size, 0, 0, 0, 2'b00,
                 vecs[0].e_wdata, vecs[0].e_strb, 1'b0, 1'b0, 3);

        // Randomized stores against the reference model
        for (int k = 0; k < 40; k++) begin
            ra    = {$urandom, $urandom};
            rd    = {$urandom, $urandom};
            rsz   = 2'($urandom_range(3, 0));
            rbr   = 2'($urandom_range(3, 0));
            rawd  = int'($urandom_range(3, 0));
            rwd   = int'($urandom_range(3, 0));
            rbd   = int'($urandom_range(3, 0));
            rmis  = m_mis(ra, rsz);
            rdone = rmis ? 1 : ((rawd > rwd) ? rawd : rwd) + rbd + 3;
            do_store($sformatf("rnd%0d", k), ra, rd, rsz, rawd, rwd, rbd, rbr,
                     m_wdata(ra, rd), m_strb(ra, rsz), rmis,
                     rmis || (BRESP_CHK && rbr[1]), rdone);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
